// File: rtl/emif_amm_arbiter_if.sv
// emif_amm_arbiter_if: one Avalon-MM link (command, write data, read return).
// The master modport issues commands; the slave modport accepts them.
interface emif_amm_arbiter_if #(
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned DATA_W  = 320,
  parameter int unsigned BE_W    = 40,
  parameter int unsigned BURST_W = 7
);
  logic                read;
  logic                write;
  logic [ADDR_W-1:0]   address;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   writedata;
  logic [BE_W-1:0]     byteenable;
  logic                ready;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output read, write, address, burstcount, writedata, byteenable,
    input  ready, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, burstcount, writedata, byteenable,
    output ready, readdata, readdatavalid
  );
endinterface

// File: rtl/emif_amm_arbiter.sv
// emif_amm_arbiter: round-robin sharing of one EMIF Avalon-MM port between two
// masters. Write bursts hold the grant; read data is steered back through an
// in-order tag FIFO. Define EMIF_AMM_ARB_PERF_EN to add grant/stall counters.
module emif_amm_arbiter #(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 320,
  parameter int unsigned BE_W      = 40,
  parameter int unsigned BURST_W   = 7,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic               emif_usr_clk,
  input  logic               emif_usr_reset_n,
  input  logic               local_cal_success,
  emif_amm_arbiter_if.slave  m0,
  emif_amm_arbiter_if.slave  m1,
  emif_amm_arbiter_if.master amm,
  output logic               rd_orphan_err
`ifdef EMIF_AMM_ARB_PERF_EN
  ,
  input  logic               perf_clr,
  output logic [31:0]        perf_grant0,
  output logic [31:0]        perf_grant1,
  output logic [31:0]        perf_stall
`endif
);
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TAG_W = BURST_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR_BURST} state_t;

  state_t             r_state;
  logic               r_grant;
  logic               r_last_grant;
  logic [BURST_W-1:0] r_beats_left;

  logic [TAG_W-1:0]   r_tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [BURST_W-1:0] r_beat_cnt;
  logic               r_orphan_err;

  logic               w_full;
  logic               w_empty;
  logic               w_elig0;
  logic               w_elig1;
  logic               w_in_cmd;
  logic               w_in_wr;
  logic               w_g_read;
  logic               w_g_write;
  logic [ADDR_W-1:0]  w_g_address;
  logic [BURST_W-1:0] w_g_burst;
  logic [DATA_W-1:0]  w_g_wdata;
  logic [BE_W-1:0]    w_g_be;
  logic               w_cmd_rd;
  logic               w_amm_write;
  logic               w_g_ready;
  logic               w_push;
  logic [TAG_W-1:0]   w_head;
  logic               w_head_tag;
  logic [BURST_W-1:0] w_head_bc;
  logic               w_rdv_ok;
  logic               w_last_beat;
  logic               w_pop;

  // Tag FIFO status and eligibility (a read needs a free tag slot)
  assign w_full  = (r_count == CNT_W'(TAG_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_elig0 = local_cal_success & (m0.write | (m0.read & ~w_full));
  assign w_elig1 = local_cal_success & (m1.write | (m1.read & ~w_full));

  // Granted-master mux
  assign w_in_cmd    = (r_state == S_CMD);
  assign w_in_wr     = (r_state == S_WR_BURST);
  assign w_g_read    = r_grant ? m1.read       : m0.read;
  assign w_g_write   = r_grant ? m1.write      : m0.write;
  assign w_g_address = r_grant ? m1.address    : m0.address;
  assign w_g_burst   = r_grant ? m1.burstcount : m0.burstcount;
  assign w_g_wdata   = r_grant ? m1.writedata  : m0.writedata;
  assign w_g_be      = r_grant ? m1.byteenable : m0.byteenable;

  // Controller command side; reads are never forwarded during a write burst
  assign w_cmd_rd    = w_in_cmd & w_g_read & ~w_g_write & ~w_full;
  assign w_amm_write = (w_in_cmd | w_in_wr) & w_g_write;

  assign amm.read       = w_cmd_rd;
  assign amm.write      = w_amm_write;
  assign amm.address    = w_in_cmd ? w_g_address : '0;
  assign amm.burstcount = w_in_cmd ? w_g_burst : '0;
  assign amm.writedata  = (w_in_cmd | w_in_wr) ? w_g_wdata : '0;
  assign amm.byteenable = (w_in_cmd | w_in_wr) ? w_g_be : '0;

  // Waitrequest_n back to the granted master only
  assign w_g_ready = amm.ready & (w_cmd_rd | w_amm_write);
  assign m0.ready  = w_g_ready & ~r_grant;
  assign m1.ready  = w_g_ready & r_grant;

  // Read return steering from the FIFO head, zero added latency
  assign w_push      = w_cmd_rd & amm.ready;
  assign w_head      = r_tag_mem[r_rd_ptr];
  assign w_head_tag  = w_head[BURST_W];
  assign w_head_bc   = w_head[BURST_W-1:0];
  assign w_rdv_ok    = amm.readdatavalid & ~w_empty;
  assign w_last_beat = ((r_beat_cnt + BURST_W'(1)) == w_head_bc);
  assign w_pop       = w_rdv_ok & w_last_beat;

  assign m0.readdata      = amm.readdata;
  assign m1.readdata      = amm.readdata;
  assign m0.readdatavalid = w_rdv_ok & ~w_head_tag;
  assign m1.readdatavalid = w_rdv_ok & w_head_tag;
  assign rd_orphan_err    = r_orphan_err;

  // Arbitration FSM: grant in IDLE, command in CMD, remaining beats in WR_BURST
  always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
    if (!emif_usr_reset_n) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beats_left <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_elig0 | w_elig1) begin
            r_grant <= (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (amm.ready & w_cmd_rd) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end else if (amm.ready & w_amm_write) begin
            if (w_g_burst <= BURST_W'(1)) begin
              r_last_grant <= r_grant;
              r_state      <= S_IDLE;
            end else begin
              r_beats_left <= w_g_burst - BURST_W'(1);
              r_state      <= S_WR_BURST;
            end
          end else if (~w_g_read & ~w_g_write) begin
            r_state <= S_IDLE;
          end
        end
        S_WR_BURST: begin
          if (amm.ready & w_amm_write) begin
            r_beats_left <= r_beats_left - BURST_W'(1);
            if (r_beats_left == BURST_W'(1)) begin
              r_last_grant <= r_grant;
              r_state      <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag FIFO storage: {master, burstcount} per accepted read
  always_ff @(posedge emif_usr_clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= {r_grant, w_g_burst};
  end

  // Tag FIFO pointers, return beat counter and sticky orphan flag
  always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
    if (!emif_usr_reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_beat_cnt   <= '0;
      r_orphan_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push & ~w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop & ~w_push) r_count <= r_count - CNT_W'(1);
      if (w_rdv_ok) r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + BURST_W'(1);
      if (amm.readdatavalid & w_empty) r_orphan_err <= 1'b1;
    end
  end

`ifdef EMIF_AMM_ARB_PERF_EN
  logic [31:0] r_perf_grant0;
  logic [31:0] r_perf_grant1;
  logic [31:0] r_perf_stall;
  logic        w_cmd_acc;
  logic        w_stall;

  assign w_cmd_acc   = w_in_cmd & w_g_ready;
  assign w_stall     = (w_in_cmd | w_in_wr) & ~amm.ready;
  assign perf_grant0 = r_perf_grant0;
  assign perf_grant1 = r_perf_grant1;
  assign perf_stall  = r_perf_stall;

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
    if (!emif_usr_reset_n) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else if (perf_clr) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_cmd_acc & ~r_grant & ~&r_perf_grant0) r_perf_grant0 <= r_perf_grant0 + 32'd1;
      if (w_cmd_acc & r_grant & ~&r_perf_grant1)  r_perf_grant1 <= r_perf_grant1 + 32'd1;
      if (w_stall & ~&r_perf_stall)               r_perf_stall  <= r_perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_emif_amm_arbiter.sv
// tb_emif_amm_arbiter: directed bench with a simple in-order controller model.
// Expected command order is queued by the stimulus; expected read beats are
// queued when the controller model accepts a read and checked on return.
module tb_emif_amm_arbiter;
  localparam int unsigned ADDR_W    = 25;
  localparam int unsigned DATA_W    = 320;
  localparam int unsigned BE_W      = 40;
  localparam int unsigned BURST_W   = 7;
  localparam int unsigned TAG_DEPTH = 8;

  typedef struct packed {
    logic              m;
    logic [DATA_W-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cal;
  logic rd_orphan_err;

  emif_amm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) m0_if ();
  emif_amm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) m1_if ();
  emif_amm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) amm_if ();

`ifdef EMIF_AMM_ARB_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif

  emif_amm_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .emif_usr_clk      (clk),
    .emif_usr_reset_n  (rst_n),
    .local_cal_success (cal),
    .m0                (m0_if),
    .m1                (m1_if),
    .amm               (amm_if),
    .rd_orphan_err     (rd_orphan_err)
`ifdef EMIF_AMM_ARB_PERF_EN
    ,
    .perf_clr          (perf_clr),
    .perf_grant0       (perf_grant0),
    .perf_grant1       (perf_grant1),
    .perf_stall        (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    exp_cmd[$];
  beat_t beatq[$];
  beat_t cur;
  bit    cur_valid;
  bit    rdv_en;
  int    orphan_req;
  bit    acc0, acc1;
  int    rv0, rv1, wbeats0, wbeats1;
  int    mon_wleft, mon_owner;
  int    n0, n1, b0, b1, base;
  bit    got;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] bdata(input logic [ADDR_W-1:0] a, input int b);
    logic [DATA_W-1:0] d;
    d = '0;
    d[ADDR_W+7:0] = {a, 8'(b)};
    d[DATA_W-1 -: 16] = 16'hBEEF;
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] wpat(input int m);
    logic [DATA_W-1:0] d;
    d = (m != 0) ? {(DATA_W/4){4'h5}} : {(DATA_W/4){4'hA}};
    return d;
  endfunction

  // One clock: controller return at negedge, monitor just after, then past posedge
  task automatic cycle();
    int exp_m;
    @(negedge clk);
    cur_valid = 1'b0;
    if (rdv_en && beatq.size() > 0) begin
      cur = beatq.pop_front();
      cur_valid = 1'b1;
      amm_if.readdatavalid = 1'b1;
      amm_if.readdata = cur.d;
    end else if (orphan_req > 0) begin
      orphan_req--;
      amm_if.readdatavalid = 1'b1;
      amm_if.readdata = '1;
    end else begin
      amm_if.readdatavalid = 1'b0;
    end
    #1;
    if (cur_valid) begin
      chk("rdv_m0", m0_if.readdatavalid, !cur.m);
      chk("rdv_m1", m1_if.readdatavalid, cur.m);
      chk("rdata", cur.m ? m1_if.readdata : m0_if.readdata, cur.d);
      if (cur.m) rv1++; else rv0++;
    end else begin
      chk("rdv_none", {m0_if.readdatavalid, m1_if.readdatavalid}, 2'b00);
    end
    if (rst_n && amm_if.ready && (amm_if.read || amm_if.write)) begin
      if (amm_if.read || mon_wleft == 0) begin
        chk("cmd_expected", exp_cmd.size() > 0, 1'b1);
        exp_m = (exp_cmd.size() > 0) ? exp_cmd.pop_front() : -1;
        chk("cmd_master", amm_if.address[9], exp_m);
        if (amm_if.read) begin
          for (int b = 0; b < int'(amm_if.burstcount); b++)
            beatq.push_back('{m: amm_if.address[9], d: bdata(amm_if.address, b)});
        end else begin
          mon_owner = int'(amm_if.address[9]);
          mon_wleft = int'(amm_if.burstcount) - 1;
        end
      end else begin
        mon_wleft--;
      end
      if (amm_if.write) begin
        chk("wdata", amm_if.writedata, wpat(mon_owner));
        if (mon_owner != 0) wbeats1++; else wbeats0++;
      end
    end
    acc0 = m0_if.ready && (m0_if.read || m0_if.write);
    acc1 = m1_if.ready && (m1_if.read || m1_if.write);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    for (int c = 0; c < limit && beatq.size() > 0; c++) cycle();
    chk("drain_done", beatq.size(), 0);
    cycle();
  endtask

  initial begin
    rst_n = 1'b1; cal = 1'b0; rdv_en = 1'b0; orphan_req = 0;
    rv0 = 0; rv1 = 0; wbeats0 = 0; wbeats1 = 0; mon_wleft = 0; mon_owner = 0;
    m0_if.read = 0; m0_if.write = 0; m0_if.address = '0; m0_if.burstcount = '0;
    m0_if.writedata = wpat(0); m0_if.byteenable = '1;
    m1_if.read = 0; m1_if.write = 0; m1_if.address = '0; m1_if.burstcount = '0;
    m1_if.writedata = wpat(1); m1_if.byteenable = '1;
    amm_if.ready = 1'b1; amm_if.readdatavalid = 1'b0; amm_if.readdata = '0;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_amm_read", amm_if.read, 0);
    chk("rst_amm_write", amm_if.write, 0);
    chk("rst_m0_ready", m0_if.ready, 0);
    chk("rst_m1_ready", m1_if.ready, 0);
    chk("rst_orphan", rd_orphan_err, 0);
    rst_n = 1'b1; cal = 1'b1;

    // Both masters stream reads of 4: commands alternate m0, m1
    for (int i = 0; i < 3; i++) begin exp_cmd.push_back(0); exp_cmd.push_back(1); end
    rdv_en = 1'b1;
    m0_if.address = ADDR_W'('h100); m0_if.burstcount = BURST_W'(4);
    m1_if.address = ADDR_W'('h200); m1_if.burstcount = BURST_W'(4);
    n0 = 0; n1 = 0;
    for (int c = 0; c < 200 && (n0 < 3 || n1 < 3); c++) begin
      m0_if.read = (n0 < 3); m1_if.read = (n1 < 3);
      cycle();
      if (acc0) n0++;
      if (acc1) n1++;
    end
    m0_if.read = 0; m1_if.read = 0;
    chk("t1_n0", n0, 3);
    chk("t1_n1", n1, 3);
    drain(100);
    chk("t1_rv0", rv0, 12);
    chk("t1_rv1", rv1, 12);
    chk("t1_cmdq", exp_cmd.size(), 0);

    // m0 burst of 8 with m1 write pending, controller ready toggling
    exp_cmd.push_back(0); exp_cmd.push_back(1);
    m0_if.burstcount = BURST_W'(8); m1_if.burstcount = BURST_W'(1);
    b0 = 0; b1 = 0;
    for (int c = 0; c < 200 && (b0 < 8 || b1 < 1); c++) begin
      amm_if.ready = (c % 2 == 1);
      m0_if.write = (b0 < 8); m1_if.write = (b1 < 1);
      cycle();
      if (acc1) begin chk("t2_m1_after_m0", b0, 8); b1++; end
      if (acc0) b0++;
    end
    m0_if.write = 0; m1_if.write = 0; amm_if.ready = 1'b1;
    cycle();
    chk("t2_b0", b0, 8);
    chk("t2_wbeats0", wbeats0, 8);
    chk("t2_wbeats1", wbeats1, 1);
    chk("t2_cmdq", exp_cmd.size(), 0);

    // Fill all tags with returns held off; the ninth read must wait
    rdv_en = 1'b0;
    m0_if.burstcount = BURST_W'(2);
    for (int i = 0; i < int'(TAG_DEPTH); i++) exp_cmd.push_back(0);
    n0 = 0;
    for (int c = 0; c < 100 && n0 < int'(TAG_DEPTH); c++) begin
      m0_if.address = ADDR_W'('h100 + n0); m0_if.read = 1;
      cycle();
      if (acc0) n0++;
    end
    chk("t3_filled", n0, TAG_DEPTH);
    for (int c = 0; c < 10; c++) begin
      m0_if.address = ADDR_W'('h108); m0_if.read = 1;
      cycle();
      chk("t3_9th_blocked", acc0, 0);
    end
    exp_cmd.push_back(0);
    base = rv0; rdv_en = 1'b1; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      cycle();
      if (acc0) begin got = 1; chk("t3_after_first_burst", (rv0 - base) >= 2, 1'b1); end
    end
    chk("t3_9th_granted", got, 1'b1);
    m0_if.read = 0;
    drain(100);
    chk("t3_cmdq", exp_cmd.size(), 0);

    // Orphan beat: dropped, sticky error
    chk("t4_pre", rd_orphan_err, 0);
    orphan_req = 1;
    cycle();
    chk("t4_err", rd_orphan_err, 1);
    repeat (5) cycle();
    chk("t4_sticky", rd_orphan_err, 1);

    // Reset in the middle of an 8-beat write
    exp_cmd.push_back(0);
    m0_if.address = ADDR_W'('h100); m0_if.burstcount = BURST_W'(8);
    b0 = 0;
    for (int c = 0; c < 50 && b0 < 3; c++) begin
      m0_if.write = 1;
      cycle();
      if (acc0) b0++;
    end
    chk("t5_three_beats", b0, 3);
    rst_n = 1'b0;
    #1;
    chk("t5_amm_write", amm_if.write, 0);
    chk("t5_wdata", amm_if.writedata, '0);
    chk("t5_m0_ready", m0_if.ready, 0);
    chk("t5_m1_ready", m1_if.ready, 0);
    chk("t5_orphan_clr", rd_orphan_err, 0);
    m0_if.write = 0; mon_wleft = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cmd.push_back(0); exp_cmd.push_back(1);
    m0_if.burstcount = BURST_W'(1); m1_if.burstcount = BURST_W'(1);
    b0 = 0; b1 = 0;
    for (int c = 0; c < 50 && (b0 < 1 || b1 < 1); c++) begin
      m0_if.write = (b0 < 1); m1_if.write = (b1 < 1);
      cycle();
      if (acc1) begin chk("t5_m0_first", b0, 1); b1++; end
      if (acc0) b0++;
    end
    m0_if.write = 0; m1_if.write = 0;
    chk("t5_both_done", b0 + b1, 2);

    // Calibration low: no commands; grant one cycle after it rises
    cal = 1'b0;
    m0_if.read = 1; m1_if.read = 1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("t6_no_cmd", {amm_if.read, amm_if.write}, 2'b00);
    end
    exp_cmd.push_back(0); exp_cmd.push_back(1);
    cal = 1'b1;
    #1 chk("t6_same_cycle", amm_if.read, 0);
    cycle();
    chk("t6_cmd_next", amm_if.read, 1);
    chk("t6_cmd_addr", amm_if.address, 'h100);
    n0 = 0; n1 = 0;
    for (int c = 0; c < 50 && (n0 < 1 || n1 < 1); c++) begin
      m0_if.read = (n0 < 1); m1_if.read = (n1 < 1);
      cycle();
      if (acc0) n0++;
      if (acc1) n1++;
    end
    m0_if.read = 0; m1_if.read = 0;
    chk("t6_both_done", n0 + n1, 2);
    drain(50);
    chk("final_cmdq", exp_cmd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
